scr1_dmem_arb: RTL and testbench

Two-port arbiter that shares a single data-memory target port between the core LSU (port 0) and a second master such as a debug or DMA engine (port 1). It sits between the requesters' DMEM interfaces and the DMEM router/TCM using the same req/ack/resp protocol on every side. It forwards one request at a time and keeps at most one transaction outstanding. It returns each response, and any error, only to the port that owns the transaction.

---
 rtl/scr1_dmem_arb_pkg.sv | 40 ++++
 rtl/scr1_dmem_arb_sel2.sv | 40 ++++
 rtl/scr1_dmem_arb.sv | 130 +++++++++++++
 tb/tb_scr1_dmem_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_dmem_arb_pkg.sv
// ============================================================================
// Module  : scr1_dmem_arb_pkg
// Purpose : DMEM interface types and widths shared by the DMEM arbiter files.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_dmem_arb_pkg;

   localparam int unsigned DMEM_AWIDTH = `SCR1_DMEM_AWIDTH;
   localparam int unsigned DMEM_DWIDTH = `SCR1_DMEM_DWIDTH;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

endpackage

`default_nettype wire

// File: rtl/scr1_dmem_arb_sel2.sv
// ============================================================================
// Module  : scr1_arb_sel2
// Purpose : Two-requester selector; round-robin when SCR1_DMEM_ARB_RR_EN is
//           defined, fixed priority to requester 0 otherwise.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_arb_sel2 (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic upd,
   output logic sel
);

`ifdef SCR1_DMEM_ARB_RR_EN
   logic r_last;

   // Reset to 1 so requester 0 wins the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (upd) begin
         r_last <= sel;
      end
   end

   assign sel = (req0 & req1) ? ~r_last : (req1 & ~req0);
`else
   logic w_unused;

   assign w_unused = &{1'b0, clk, rst_n, upd};
   assign sel      = req1 & ~req0;
`endif

endmodule

`default_nettype wire

// File: rtl/scr1_dmem_arb.sv
// ============================================================================
// Module  : scr1_dmem_arb
// Purpose : Shares one DMEM target between the LSU (port 0) and a second
//           master (port 1); one outstanding transaction. Round-robin under
//           SCR1_DMEM_ARB_RR_EN, assertions under SCR1_SIM_ENV.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scr1_dmem_arb
   import scr1_dmem_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic                   m0_req,
   input  type_scr1_mem_cmd_e     m0_cmd,
   input  type_scr1_mem_width_e   m0_width,
   input  logic [DMEM_AWIDTH-1:0] m0_addr,
   input  logic [DMEM_DWIDTH-1:0] m0_wdata,
   output logic                   m0_req_ack,
   output logic [DMEM_DWIDTH-1:0] m0_rdata,
   output type_scr1_mem_resp_e    m0_resp,

   input  logic                   m1_req,
   input  type_scr1_mem_cmd_e     m1_cmd,
   input  type_scr1_mem_width_e   m1_width,
   input  logic [DMEM_AWIDTH-1:0] m1_addr,
   input  logic [DMEM_DWIDTH-1:0] m1_wdata,
   output logic                   m1_req_ack,
   output logic [DMEM_DWIDTH-1:0] m1_rdata,
   output type_scr1_mem_resp_e    m1_resp,

   output logic                   arb2dmem_req,
   output type_scr1_mem_cmd_e     arb2dmem_cmd,
   output type_scr1_mem_width_e   arb2dmem_width,
   output logic [DMEM_AWIDTH-1:0] arb2dmem_addr,
   output logic [DMEM_DWIDTH-1:0] arb2dmem_wdata,
   input  logic                   dmem2arb_req_ack,
   input  logic [DMEM_DWIDTH-1:0] dmem2arb_rdata,
   input  type_scr1_mem_resp_e    dmem2arb_resp
);

   typedef enum logic {
      SCR1_ARB_IDLE = 1'b0,
      SCR1_ARB_BUSY = 1'b1
   } type_scr1_arb_fsm_e;

   type_scr1_arb_fsm_e r_state;
   logic               r_owner;
   logic               w_sel;
   logic               w_idle;
   logic               w_busy;
   logic               w_accept;
   logic               w_resp_done;
   logic               w_route0;
   logic               w_route1;

   assign w_idle      = (r_state == SCR1_ARB_IDLE);
   assign w_busy      = (r_state == SCR1_ARB_BUSY);
   assign w_accept    = arb2dmem_req & dmem2arb_req_ack;
   assign w_resp_done = (dmem2arb_resp == SCR1_MEM_RESP_RDY_OK)
                      | (dmem2arb_resp == SCR1_MEM_RESP_RDY_ER);

   scr1_arb_sel2 i_sel2 (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (m0_req),
      .req1  (m1_req),
      .upd   (w_accept),
      .sel   (w_sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SCR1_ARB_IDLE;
         r_owner <= 1'b0;
      end else begin
         case (r_state)
            SCR1_ARB_IDLE: begin
               if (w_accept) begin
                  r_state <= SCR1_ARB_BUSY;
                  r_owner <= w_sel;
               end
            end
            SCR1_ARB_BUSY: begin
               if (w_resp_done) begin
                  r_state <= SCR1_ARB_IDLE;
               end
            end
            default: r_state <= SCR1_ARB_IDLE;
         endcase
      end
   end

   // Request path is purely combinational so an LSU sees no extra latency.
   assign arb2dmem_req   = w_idle & (m0_req | m1_req);
   assign arb2dmem_cmd   = w_sel ? m1_cmd   : m0_cmd;
   assign arb2dmem_width = w_sel ? m1_width : m0_width;
   assign arb2dmem_addr  = w_sel ? m1_addr  : m0_addr;
   assign arb2dmem_wdata = w_sel ? m1_wdata : m0_wdata;

   assign m0_req_ack = w_idle & m0_req & ~w_sel & dmem2arb_req_ack;
   assign m1_req_ack = w_idle & m1_req &  w_sel & dmem2arb_req_ack;

   assign w_route0 = w_busy & ~r_owner;
   assign w_route1 = w_busy &  r_owner;

   assign m0_resp  = w_route0 ? dmem2arb_resp  : SCR1_MEM_RESP_NOTRDY;
   assign m0_rdata = w_route0 ? dmem2arb_rdata : '0;
   assign m1_resp  = w_route1 ? dmem2arb_resp  : SCR1_MEM_RESP_NOTRDY;
   assign m1_rdata = w_route1 ? dmem2arb_rdata : '0;

`ifdef SCR1_SIM_ENV
   a_req_known : assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({m0_req, m1_req, arb2dmem_req}));

   a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({m0_req_ack, m1_req_ack}));

   a_no_resp_idle : assert property (@(posedge clk) disable iff (!rst_n)
      w_idle |-> (dmem2arb_resp == SCR1_MEM_RESP_NOTRDY));

   a_no_ack_busy : assert property (@(posedge clk) disable iff (!rst_n)
      w_busy |-> !(m0_req_ack | m1_req_ack));
`endif

endmodule

`default_nettype wire

// File: tb/tb_scr1_dmem_arb.sv
// ============================================================================
// Module  : tb_scr1_dmem_arb
// Purpose : Self-checking bench for scr1_dmem_arb (either arbitration build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scr1_dmem_arb;
   import scr1_dmem_arb_pkg::*;

   logic                 clk;
   logic                 rst_n;
   logic                 m0_req, m1_req;
   type_scr1_mem_cmd_e   m0_cmd, m1_cmd;
   type_scr1_mem_width_e m0_width, m1_width;
   logic [31:0]          m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic                 m0_req_ack, m1_req_ack;
   logic [31:0]          m0_rdata, m1_rdata;
   type_scr1_mem_resp_e  m0_resp, m1_resp;
   logic                 arb2dmem_req;
   type_scr1_mem_cmd_e   arb2dmem_cmd;
   type_scr1_mem_width_e arb2dmem_width;
   logic [31:0]          arb2dmem_addr, arb2dmem_wdata;
   logic                 dmem2arb_req_ack;
   logic [31:0]          dmem2arb_rdata;
   type_scr1_mem_resp_e  dmem2arb_resp;

   int checks   = 0;
   int failures = 0;
   logic m_last = 1'b1;

   typedef struct {
      logic               port;
      logic [31:0]        data;
      type_scr1_mem_resp_e resp;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic               r0, r1;
      logic [31:0]        a0, a1;
      logic               exp_req;
      logic [31:0]        exp_addr;
      type_scr1_mem_cmd_e exp_cmd;
      logic [31:0]        exp_wdata;
   } vec_t;
   vec_t vecs[4];

   scr1_dmem_arb dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .m0_req           (m0_req),
      .m0_cmd           (m0_cmd),
      .m0_width         (m0_width),
      .m0_addr          (m0_addr),
      .m0_wdata         (m0_wdata),
      .m0_req_ack       (m0_req_ack),
      .m0_rdata         (m0_rdata),
      .m0_resp          (m0_resp),
      .m1_req           (m1_req),
      .m1_cmd           (m1_cmd),
      .m1_width         (m1_width),
      .m1_addr          (m1_addr),
      .m1_wdata         (m1_wdata),
      .m1_req_ack       (m1_req_ack),
      .m1_rdata         (m1_rdata),
      .m1_resp          (m1_resp),
      .arb2dmem_req     (arb2dmem_req),
      .arb2dmem_cmd     (arb2dmem_cmd),
      .arb2dmem_width   (arb2dmem_width),
      .arb2dmem_addr    (arb2dmem_addr),
      .arb2dmem_wdata   (arb2dmem_wdata),
      .dmem2arb_req_ack (dmem2arb_req_ack),
      .dmem2arb_rdata   (dmem2arb_rdata),
      .dmem2arb_resp    (dmem2arb_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic conflict_grant();
`ifdef SCR1_DMEM_ARB_RR_EN
      return ~m_last;
`else
      return 1'b0;
`endif
   endfunction

   // Response scoreboard: any non-NOTRDY response must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      #3;
      if (m0_resp != SCR1_MEM_RESP_NOTRDY || m1_resp != SCR1_MEM_RESP_NOTRDY) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp m0_resp=%0h m1_resp=%0h required=none", m0_resp, m1_resp);
         end else begin
            e = sb_q.pop_front();
            if (e.port) begin
               chk("sb_m1_resp",  64'(m1_resp),  64'(e.resp));
               chk("sb_m1_rdata", 64'(m1_rdata), 64'(e.data));
               chk("sb_m0_resp",  64'(m0_resp),  64'(SCR1_MEM_RESP_NOTRDY));
               chk("sb_m0_rdata", 64'(m0_rdata), 64'(0));
            end else begin
               chk("sb_m0_resp",  64'(m0_resp),  64'(e.resp));
               chk("sb_m0_rdata", 64'(m0_rdata), 64'(e.data));
               chk("sb_m1_resp",  64'(m1_resp),  64'(SCR1_MEM_RESP_NOTRDY));
               chk("sb_m1_rdata", 64'(m1_rdata), 64'(0));
            end
         end
      end
   end

   task automatic accept_txn(input logic r0, input logic r1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input type_scr1_mem_cmd_e c0, input type_scr1_mem_cmd_e c1,
                             output logic g);
      @(negedge clk);
      m0_req = r0; m1_req = r1; m0_addr = a0; m1_addr = a1;
      m0_cmd = c0; m1_cmd = c1; dmem2arb_req_ack = 1'b1;
      g = (r0 & r1) ? conflict_grant() : r1;
      #2;
      chk("acc_req",   64'(arb2dmem_req), 64'(1));
      chk("acc_ack0",  64'(m0_req_ack),   64'(!g));
      chk("acc_ack1",  64'(m1_req_ack),   64'(g));
      chk("acc_addr",  64'(arb2dmem_addr), 64'(g ? a1 : a0));
      chk("acc_cmd",   64'(arb2dmem_cmd),  64'(g ? c1 : c0));
      chk("acc_wdata", 64'(arb2dmem_wdata), 64'(g ? m1_wdata : m0_wdata));
      m_last = g;
   endtask

   task automatic respond(input logic g, input int delay, input type_scr1_mem_resp_e r,
                          input logic [31:0] d, input logic k0, input logic k1);
      exp_t e;
      for (int i = 1; i < delay; i++) begin
         @(negedge clk);
         m0_req = k0; m1_req = k1; dmem2arb_req_ack = 1'b0;
         #2;
         chk("busy_req",  64'(arb2dmem_req), 64'(0));
         chk("busy_resp", 64'({m0_resp, m1_resp}), 64'(0));
      end
      @(negedge clk);
      m0_req = k0; m1_req = k1; dmem2arb_req_ack = 1'b0;
      dmem2arb_resp = r; dmem2arb_rdata = d;
      e.port = g; e.data = d; e.resp = r;
      sb_q.push_back(e);
      #2;
      chk("resp_no_fwd", 64'(arb2dmem_req), 64'(0));
      chk("resp_no_ack", 64'({m0_req_ack, m1_req_ack}), 64'(0));
      chk("resp_other",  64'(g ? m0_resp : m1_resp), 64'(SCR1_MEM_RESP_NOTRDY));
      @(negedge clk);
      dmem2arb_resp = SCR1_MEM_RESP_NOTRDY; dmem2arb_rdata = '0;
      #2;
      chk("idle_fwd", 64'(arb2dmem_req), 64'(k0 | k1));
   endtask

   initial begin
      logic g;
      vecs[0] = '{1'b0, 1'b0, 32'h111, 32'h222, 1'b0, 32'h111, SCR1_MEM_CMD_RD, 32'h0A0A0A0A};
      vecs[1] = '{1'b1, 1'b0, 32'h111, 32'h222, 1'b1, 32'h111, SCR1_MEM_CMD_RD, 32'h0A0A0A0A};
      vecs[2] = '{1'b0, 1'b1, 32'h111, 32'h222, 1'b1, 32'h222, SCR1_MEM_CMD_WR, 32'h0B0B0B0B};
      vecs[3] = '{1'b1, 1'b1, 32'h111, 32'h222, 1'b1, 32'h111, SCR1_MEM_CMD_RD, 32'h0A0A0A0A};

      rst_n = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      m0_cmd = SCR1_MEM_CMD_RD; m1_cmd = SCR1_MEM_CMD_WR;
      m0_width = SCR1_MEM_WIDTH_WORD; m1_width = SCR1_MEM_WIDTH_WORD;
      m0_addr = '0; m1_addr = '0;
      m0_wdata = 32'h0A0A0A0A; m1_wdata = 32'h0B0B0B0B;
      dmem2arb_req_ack = 1'b0; dmem2arb_rdata = '0;
      dmem2arb_resp = SCR1_MEM_RESP_NOTRDY;

      // Reset state
      #2;
      chk("rst_acks",  64'({m0_req_ack, m1_req_ack}), 64'(0));
      chk("rst_m0_resp", 64'(m0_resp), 64'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_m1_resp", 64'(m1_resp), 64'(SCR1_MEM_RESP_NOTRDY));
      chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
      chk("rst_req_idle", 64'(arb2dmem_req), 64'(0));
      m0_req = 1'b1;
      #1;
      chk("rst_req_follow", 64'(arb2dmem_req), 64'(1));
      m0_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Combinational forwarding table (target never acks here)
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         m0_req = vecs[i].r0; m1_req = vecs[i].r1;
         m0_addr = vecs[i].a0; m1_addr = vecs[i].a1;
         #2;
         chk("tbl_req",   64'(arb2dmem_req),   64'(vecs[i].exp_req));
         chk("tbl_addr",  64'(arb2dmem_addr),  64'(vecs[i].exp_addr));
         chk("tbl_cmd",   64'(arb2dmem_cmd),   64'(vecs[i].exp_cmd));
         chk("tbl_wdata", 64'(arb2dmem_wdata), 64'(vecs[i].exp_wdata));
         chk("tbl_acks",  64'({m0_req_ack, m1_req_ack}), 64'(0));
      end

      // Port 0 LW with OK after one cycle
      accept_txn(1'b1, 1'b0, 32'h100, 32'h0, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, g);
      respond(g, 1, SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, 1'b0, 1'b0);

      // Port 1 SW with error after three cycles, then confirm IDLE forwarding
      m1_wdata = 32'h12345678;
      accept_txn(1'b0, 1'b1, 32'h0, 32'h200, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR, g);
      respond(g, 3, SCR1_MEM_RESP_RDY_ER, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      m0_req = 1'b1;
      #2;
      chk("after_err_idle", 64'(arb2dmem_req), 64'(1));
      @(negedge clk);
      m0_req = 1'b0;

      // Continuous conflict: 4 back-to-back transactions
      for (int i = 0; i < 4; i++) begin
         accept_txn(1'b1, 1'b1, 32'h300, 32'h400, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR, g);
         respond(g, 1, SCR1_MEM_RESP_RDY_OK, 32'hA0 + 32'(i), 1'b1, 1'b1);
      end

      // Target withholds ack for 5 cycles while both request
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h500; m1_addr = 32'h600;
         dmem2arb_req_ack = 1'b0;
         #2;
         chk("hold_addr", 64'(arb2dmem_addr), 64'(conflict_grant() ? 32'h600 : 32'h500));
         chk("hold_acks", 64'({m0_req_ack, m1_req_ack}), 64'(0));
      end
      accept_txn(1'b1, 1'b1, 32'h500, 32'h600, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR, g);
      respond(g, 2, SCR1_MEM_RESP_RDY_OK, 32'h5A5A5A5A, 1'b0, 1'b0);

      // m0 re-request in the response cycle: forwarded only the cycle after
      accept_txn(1'b1, 1'b0, 32'h700, 32'h0, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, g);
      respond(g, 1, SCR1_MEM_RESP_RDY_OK, 32'h77, 1'b1, 1'b0);
      @(negedge clk);
      m0_req = 1'b0;

      // Reset while BUSY, stray response during reset
      accept_txn(1'b0, 1'b1, 32'h0, 32'h800, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, g);
      @(negedge clk);
      rst_n = 1'b0; m1_req = 1'b0; dmem2arb_req_ack = 1'b0;
      #2;
      chk("midrst_m1_resp", 64'(m1_resp), 64'(SCR1_MEM_RESP_NOTRDY));
      @(negedge clk);
      dmem2arb_resp = SCR1_MEM_RESP_RDY_OK; dmem2arb_rdata = 32'h55;
      #2;
      chk("stray_resp",  64'({m0_resp, m1_resp}), 64'(0));
      chk("stray_rdata", 64'({m0_rdata, m1_rdata}), 64'(0));
      m_last = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; dmem2arb_resp = SCR1_MEM_RESP_NOTRDY; dmem2arb_rdata = '0;
      accept_txn(1'b1, 1'b1, 32'h900, 32'hA00, SCR1_MEM_CMD_RD, SCR1_MEM_CMD_RD, g);
      respond(g, 1, SCR1_MEM_RESP_RDY_OK, 32'h99, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 64'(sb_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
